conv2d_stream: RTL
==================

// Module: conv2d_stream
// PURPOSE
//  Streaming, parametrised successor to the flat-bus 9x9 convolution block. Accepts a raster-scan
//  pixel stream over a valid/ready handshake and buffers K-1 rows in line buffers. Applies a
//  programmable signed KxK kernel with zero padding ("same" size). Emits one saturated output
//  pixel per input position, in raster order. Sits between the image source and the frame sink.
// PARAMETERS
//  IMG_W   9  pixels per row (>= K)
//  IMG_H   9  rows per frame (>= K)
//  PIX_W   8  unsigned pixel width, in and out
//  K       3  kernel size; odd, 3 or 5
//  COEF_W  4  signed two's-complement coefficient width
//  SHIFT   0  arithmetic right shift applied to the accumulator before saturation
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               synchronous, active-high reset
//  enable     in   1               frame start request; sampled only in IDLE
//  coef_we    in   1               coefficient write strobe
//  coef_addr  in   clog2(K*K)      coefficient index, row-major (0 = top-left)
//  coef_data  in   COEF_W          signed coefficient value
//  in_valid   in   1               input pixel valid
//  in_ready   out  1               block can accept a pixel
//  in_pixel   in   PIX_W           input pixel, raster order
//  out_valid  out  1               output pixel valid
//  out_ready  in   1               sink accepts the output pixel
//  out_pixel  out  PIX_W           convolved, saturated pixel
//  busy       out  1               high in RUN and FLUSH
//  done       out  1               one-cycle pulse after the last output handshake
// BEHAVIOUR
//  Reset: all outputs 0. FSM goes to IDLE. Row/column counters, line buffers, window and all
//   coefficients clear to 0. Reset mid-frame abandons the frame; no done pulse.
//  FSM: IDLE -enable-> RUN -last input accepted-> FLUSH -last output taken-> DONE -> IDLE.
//   DONE lasts 1 cycle and asserts done.
//  Coefficients: written only in IDLE, one per cycle when coef_we=1. Writes in other states are
//   ignored. Address >= K*K is ignored. Values are retained across frames.
//  Input: in_ready = (state==RUN) && advance, where advance = !out_valid || out_ready.
//   A pixel is consumed on in_valid && in_ready. Exactly IMG_W*IMG_H pixels per frame.
//  Window: each advance shifts the KxK window one column. Out-of-frame taps read 0 (row<0,
//   row>=IMG_H, col<0, col>=IMG_W). Padding is selected by counters, never stored data.
//  Flush: FLUSH supplies (K/2)*IMG_W + K/2 zero pseudo-pixels, one per advance, with no input
//   handshake. The final outputs drain through the same path.
//  Output for (r,c): registered. out_valid rises the cycle after the advance that completes
//   window (r,c), i.e. after input index r*IMG_W+c+(K/2)*IMG_W+K/2 is consumed or flushed.
//   out_valid and out_pixel hold stable until out_ready. Back-to-back throughput: 1 pixel/clk.
//   Exactly IMG_W*IMG_H outputs per frame.
//  Arithmetic: acc = sum(coef_signed * {1'b0,pixel}).
//   Width: PIX_W+COEF_W+clog2(K*K)+1 bits, signed. acc >>>= SHIFT.
//   Saturate: acc<0 -> 0; acc>2^PIX_W-1 -> 2^PIX_W-1.
//  Simultaneous: enable outside IDLE is ignored. in_valid outside RUN is not accepted.
//   coef_we together with enable in IDLE: the write lands and RUN starts next cycle.
// STRUCTURE
//  Package conv2d_pkg: state enum (IDLE, RUN, FLUSH, DONE) and function sat_pix(acc)
//   implementing clamp plus shift.
//  Sub-module conv2d_line_buf: one IMG_W-deep, PIX_W-wide shift RAM with a shift enable.
//   K-1 instances are generated. The window regs, MAC tree and FSM live in the top.
// TESTING
//  1 Centre coef=1, others 0; IMG(i,j)=3i+j+3 (9x9) -> output equals input for all 81 pixels,
//    in order, followed by a single done pulse.
//  2 All coefs=1; constant image 10 -> interior 90, edges 60, corners 40.
//  3 All coefs=7; image 255 -> every output 255 (upper saturation).
//    All coefs=-1; image 200 -> every output 0 (lower saturation).
//  4 Test 1 with out_ready toggling 1010... and random in_valid gaps -> identical 81-pixel
//    sequence; no pixel lost or duplicated; out_pixel stable while stalled.
//  5 coef_we (addr 4, data 2) during RUN -> ignored; the frame still matches test 1.
//    Write in IDLE -> every output doubles.
//  6 rst asserted after 40 inputs -> next cycle all outputs 0, state IDLE, coefs 0.
//    A new frame then runs cleanly.

Source files
------------

// File: rtl/conv2d_pkg.sv
// Shared types and helpers for the streaming KxK convolution block.
// Holds the frame-sequencing state encoding and the shift-and-clamp output stage.
package conv2d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Arithmetic shift, then clamp to [0, 2^pix_w-1]; caller truncates to its pixel width.
    function automatic logic [31:0] sat_pix(input logic signed [63:0] acc,
                                            input int unsigned       shift,
                                            input int unsigned       pix_w);
        logic signed [63:0] a;
        logic signed [63:0] maxv;
        a    = acc >>> shift;
        maxv = (64'sd1 <<< pix_w) - 64'sd1;
        if (a < 64'sd0) begin
            return '0;
        end else if (a > maxv) begin
            return maxv[31:0];
        end else begin
            return a[31:0];
        end
    endfunction

endpackage

// File: rtl/conv2d_stream_if.sv
// Pixel stream handshake bundle: input valid/ready/pixel and output valid/ready/pixel.
// master = image source + frame sink side, slave = convolution block.
interface conv2d_stream_if #(
    parameter int unsigned PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_pixel
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_pixel
    );
endinterface

// File: rtl/conv2d_line_buf.sv
// One row of pixel history: a DEPTH-deep shift register advanced by en.
// dout is the pixel that entered DEPTH shifts earlier (the same column one row up).
module conv2d_line_buf #(
    parameter int unsigned DEPTH = 9,
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);
    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (en) begin
            mem[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[DEPTH-1];
endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK signed convolution with zero padding ("same" size) and saturated output.
// Line buffers supply K-1 rows of history; the window shifts one column per advance.
module conv2d_stream
    import conv2d_pkg::*;
#(
    parameter int unsigned IMG_W  = 9,
    parameter int unsigned IMG_H  = 9,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned COEF_W = 4,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         coef_we,
    input  logic [$clog2(K*K)-1:0]       coef_addr,
    input  logic signed [COEF_W-1:0]     coef_data,
    conv2d_stream_if.slave               st,
    output logic                         busy,
    output logic                         done
);
    localparam int unsigned NTAP  = K * K;
    localparam int unsigned HALF  = K / 2;
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned DLY   = HALF * IMG_W + HALF;
    localparam int unsigned SW    = $clog2(NPIX + DLY + 1);
    localparam int unsigned RW    = $clog2(IMG_H + 1);
    localparam int unsigned CW    = $clog2(IMG_W + 1);
    localparam int unsigned ACC_W = PIX_W + COEF_W + $clog2(NTAP) + 1;

    state_t state, state_n;

    logic signed [COEF_W-1:0] coef [NTAP];
    logic [PIX_W-1:0]         win   [K][K];
    logic [PIX_W-1:0]         win_n [K][K];
    logic [PIX_W-1:0]         tap   [K];
    logic [SW-1:0]            s;
    logic [RW-1:0]            cr;
    logic [CW-1:0]            cc;
    logic                     fl_end;
    logic                     advance, step, emit;
    logic signed [ACC_W-1:0]  acc;

    assign advance     = !st.out_valid || st.out_ready;
    assign st.in_ready = (state == RUN) && advance;
    assign step        = (state == RUN)   ? (st.in_valid && advance)
                       : (state == FLUSH) ? (advance && !fl_end) : 1'b0;
    // s counts stream positions; the window centre lags the newest pixel by DLY positions.
    assign emit        = step && (s >= SW'(DLY));
    assign tap[K-1]    = (state == RUN) ? st.in_pixel : '0;

    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        conv2d_line_buf #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb (
            .clk  (clk),
            .rst  (rst),
            .en   (step),
            .din  (tap[K-1-g]),
            .dout (tap[K-2-g])
        );
    end

    // Padding comes from the centre row/column counters, so stale buffer contents never leak in.
    always_comb begin : p_mac
        int rr;
        int cn;
        logic signed [ACC_W-1:0] cx;
        logic signed [ACC_W-1:0] px;
        rr  = 0;
        cn  = 0;
        cx  = '0;
        px  = '0;
        acc = '0;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K - 1; j++) win_n[i][j] = win[i][j+1];
            win_n[i][K-1] = tap[i];
        end
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K; j++) begin
                rr = int'(cr) + int'(i) - int'(HALF);
                cn = int'(cc) + int'(j) - int'(HALF);
                if (rr >= 0 && rr < int'(IMG_H) && cn >= 0 && cn < int'(IMG_W)) begin
                    cx  = ACC_W'(coef[i*K+j]);
                    px  = ACC_W'({1'b0, win_n[i][j]});
                    acc = acc + cx * px;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned a = 0; a < NTAP; a++) coef[a] <= '0;
            for (int unsigned i = 0; i < K; i++)
                for (int unsigned j = 0; j < K; j++) win[i][j] <= '0;
            s            <= '0;
            cr           <= '0;
            cc           <= '0;
            fl_end       <= 1'b0;
            st.out_valid <= 1'b0;
            st.out_pixel <= '0;
        end else begin
            if (state == IDLE && coef_we && (int'(coef_addr) < int'(NTAP)))
                coef[coef_addr] <= coef_data;
            if (state == IDLE && enable) begin
                s      <= '0;
                cr     <= '0;
                cc     <= '0;
                fl_end <= 1'b0;
            end
            if (step) begin
                win <= win_n;
                s   <= s + 1'b1;
                if (emit) begin
                    if (cc == CW'(IMG_W - 1)) begin
                        cc <= '0;
                        cr <= cr + 1'b1;
                    end else begin
                        cc <= cc + 1'b1;
                    end
                end
                if (state == FLUSH && s == SW'(NPIX + DLY - 1)) fl_end <= 1'b1;
            end
            if (advance) st.out_valid <= emit;
            if (emit)    st.out_pixel <= PIX_W'(sat_pix(64'(acc), SHIFT, PIX_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE:    if (enable) state_n = RUN;
            RUN: begin
                busy = 1'b1;
                if (step && s == SW'(NPIX - 1)) state_n = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (fl_end && st.out_valid && st.out_ready) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
